// File: rtl/i2s_rx.sv
// I2S receiver: oversamples external SCLK/LRCLK/SDIN in the Clk domain, aligns to
// the stereo frame and presents each completed frame on a valid/ready interface.
module i2s_rx #(
    parameter int DATAWIDTH = 24,
    parameter int TIMEOUT   = 4096,
    parameter int TOW       = 13
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 En,
    input  logic                 SCLK,
    input  logic                 LRCLK,
    input  logic                 SDIN,
    output logic [DATAWIDTH-1:0] sampL,
    output logic [DATAWIDTH-1:0] sampR,
    output logic                 sampValid,
    input  logic                 sampReady,
    output logic                 overrun,
    input  logic                 overrunClr,
    output logic                 locked
);

    localparam int CW = $clog2(DATAWIDTH + 1);
    localparam logic [DATAWIDTH-1:0] MSB_ONE = {1'b1, {(DATAWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ALIGN,
        RUN_L,
        RUN_R
    } state_e;

    // Reset asserts asynchronously but releases on a Clk edge.
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n_int = rst_sync_q[1];

    // Pin synchronisers and registered SCLK rising-edge detector.
    logic [1:0] sclk_sync_q, lr_sync_q, sd_sync_q;
    logic       sclk_prev_q, tick_q, lr_tick_q, sd_tick_q;

    // NOTE: every flop is written with <= so all registers update from pre-edge values.
    always_ff @(posedge Clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            sclk_sync_q <= '0;
            lr_sync_q   <= '0;
            sd_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            tick_q      <= 1'b0;
            lr_tick_q   <= 1'b0;
            sd_tick_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], SCLK};
            lr_sync_q   <= {lr_sync_q[0], LRCLK};
            sd_sync_q   <= {sd_sync_q[0], SDIN};
            sclk_prev_q <= sclk_sync_q[1];
            tick_q      <= sclk_sync_q[1] & ~sclk_prev_q;
            lr_tick_q   <= lr_sync_q[1];
            sd_tick_q   <= sd_sync_q[1];
        end
    end

    state_e                 state_q, state_d;
    logic                   lr_prev_q, lr_prev_d;
    logic [DATAWIDTH-1:0]   word_q, word_d;
    logic [CW-1:0]          bitcnt_q, bitcnt_d;
    logic [DATAWIDTH-1:0]   hold_l_q, hold_l_d;
    logic [TOW-1:0]         wd_q, wd_d;
    logic [DATAWIDTH-1:0]   samp_l_q, samp_l_d;
    logic [DATAWIDTH-1:0]   samp_r_q, samp_r_d;
    logic                   valid_q, valid_d;
    logic                   overrun_q, overrun_d;

    logic timeout, lr_edge, frame_done, start_word, shift_bit;

    assign timeout = (wd_q == TOW'(TIMEOUT));
    assign lr_edge = (lr_tick_q != lr_prev_q);

    always_ff @(posedge Clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q   <= ALIGN;
            lr_prev_q <= 1'b0;
            word_q    <= '0;
            bitcnt_q  <= '0;
            hold_l_q  <= '0;
            wd_q      <= '0;
            samp_l_q  <= '0;
            samp_r_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lr_prev_q <= lr_prev_d;
            word_q    <= word_d;
            bitcnt_q  <= bitcnt_d;
            hold_l_q  <= hold_l_d;
            wd_q      <= wd_d;
            samp_l_q  <= samp_l_d;
            samp_r_q  <= samp_r_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        lr_prev_d  = lr_prev_q;
        word_d     = word_q;
        bitcnt_d   = bitcnt_q;
        hold_l_d   = hold_l_q;
        wd_d       = wd_q;
        samp_l_d   = samp_l_q;
        samp_r_d   = samp_r_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q;
        frame_done = 1'b0;
        start_word = 1'b0;
        shift_bit  = 1'b0;

        // Watchdog saturates at TIMEOUT so a stalled SCLK holds the block in ALIGN.
        if (tick_q) begin
            wd_d      = '0;
            lr_prev_d = lr_tick_q;
        end else if (!timeout) begin
            wd_d = wd_q + 1'b1;
        end

        if (!En || timeout) begin
            state_d = ALIGN;
        end else if (tick_q) begin
            case (state_q)
                ALIGN: begin
                    if (lr_prev_q && !lr_tick_q) begin
                        start_word = 1'b1;
                        state_d    = RUN_L;
                    end
                end
                RUN_L: begin
                    if (lr_edge) begin
                        hold_l_d   = word_q;
                        start_word = 1'b1;
                        state_d    = RUN_R;
                    end else begin
                        shift_bit = 1'b1;
                    end
                end
                RUN_R: begin
                    if (lr_edge) begin
                        frame_done = 1'b1;
                        start_word = 1'b1;
                        state_d    = RUN_L;
                    end else begin
                        shift_bit = 1'b1;
                    end
                end
                default: state_d = ALIGN;
            endcase
        end

        // Bits land MSB-first; anything past DATAWIDTH is dropped, short words stay zero-padded.
        if (start_word) begin
            word_d   = '0;
            bitcnt_d = '0;
        end else if (shift_bit && (bitcnt_q < CW'(DATAWIDTH))) begin
            if (sd_tick_q) word_d = word_q | (MSB_ONE >> bitcnt_q);
            bitcnt_d = bitcnt_q + 1'b1;
        end

        if (frame_done && (!valid_q || sampReady)) begin
            samp_l_d = hold_l_q;
            samp_r_d = word_q;
            valid_d  = 1'b1;
        end else if (valid_q && sampReady) begin
            valid_d = 1'b0;
        end

        if (frame_done && valid_q && !sampReady) overrun_d = 1'b1;
        else if (overrunClr)                     overrun_d = 1'b0;
    end

    assign sampL     = samp_l_q;
    assign sampR     = samp_r_q;
    assign sampValid = valid_q;
    assign overrun   = overrun_q;
    assign locked    = (state_q != ALIGN);

endmodule
